// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
//   Definitions shared by the multi-cycle sequencer and the datapath:
//   - opcode values (IR[31:26]) of the supported instructions
//   - instruction class encoding produced by mc_opclass_dec
//   - sequencer state encoding (also visible on the debug `state` port)
//   - pc_src / alu_src_b / alu_op select encodings
//   - ctrl_t: the control word driven by the sequencer each cycle
// ---------------------------------------------------------------------------
package mc_pkg;

    // Opcodes recognised by the sequencer.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Instruction class. Reset value of the latched class is CLS_RTYPE (all zeros).
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ADDI    = 3'd1,
        CLS_LW      = 3'd2,
        CLS_SW      = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_J       = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    // Sequencer states; the encodings are architectural (debug port).
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FETCH  = 3'b001,
        ST_DECODE = 3'b010,
        ST_EXEC   = 3'b011,
        ST_MEM    = 3'b100,
        ST_WB     = 3'b101,
        ST_HALT   = 3'b110
    } state_t;

    // PC source select.
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch target
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump target

    // ALU B operand select.
    localparam logic [1:0] ALU_B_RT   = 2'b00;     // register rt
    localparam logic [1:0] ALU_B_FOUR = 2'b01;     // constant 4
    localparam logic [1:0] ALU_B_IMM  = 2'b10;     // sign-extended immediate

    // ALU operation select.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;   // decoded from funct field

    // One cycle's worth of datapath control.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       mdr_we;
        logic       pc_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       instr_done;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Classes that visit the MEM state.
    function automatic logic is_mem_class(input op_class_t cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/mc_opclass_dec.sv
// ---------------------------------------------------------------------------
// mc_opclass_dec
//   Purely combinational opcode-to-class decoder.
//   Ports:
//     op_code   in  6  IR[31:26]
//     op_class  out 3  instruction class (op_class_t); unknown -> CLS_ILLEGAL
// ---------------------------------------------------------------------------
module mc_opclass_dec
    import mc_pkg::*;
(
    input  logic [5:0] op_code,
    output op_class_t  op_class
);

    always_comb begin
        case (op_code)
            OP_RTYPE: op_class = CLS_RTYPE;
            OP_ADDI:  op_class = CLS_ADDI;
            OP_LW:    op_class = CLS_LW;
            OP_SW:    op_class = CLS_SW;
            OP_BEQ:   op_class = CLS_BEQ;
            OP_J:     op_class = CLS_J;
            default:  op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
//   Multi-cycle control sequencer. Walks the shared datapath through
//   FETCH, DECODE, EXEC, MEM and WB, one state per cycle, and sequences the
//   single shared memory port.
//
//   Memory handshake: while mem_req is high, mem_req/mem_we/iord are held
//   stable; the request completes in the cycle mem_ack is sampled high.
//   A request that has stayed unacknowledged for MAX_WAIT cycles and is still
//   unacknowledged on the next cycle ends in HALT with bus_err set; an ack in
//   that last cycle still completes normally.
//
//   Parameters:
//     MAX_WAIT  unacknowledged cycles tolerated before a bus error (15)
//     CNT_W     performance counter width (only with MC_SEQ_PERF_CNT_EN)
//
//   Ports:
//     clk, rst            clock (rising edge), async active-low reset
//     run                 permits starting a new instruction
//     opCode              IR[31:26], valid from DECODE onward
//     zero                ALU zero flag, used by BEQ in EXEC
//     mem_ack             memory completes the current request this cycle
//     mem_req, mem_we     memory request / write
//     iord                address select: 0 = PC, 1 = ALUOut
//     ir_we, mdr_we       IR / MDR write enables
//     pc_we, reg_we       PC / register file write enables
//     pc_src, alu_src_b,
//     alu_op              datapath selects (encodings in mc_pkg)
//     reg_dst, mem_to_reg write-back selects
//     instr_done          one-cycle pulse when an instruction retires
//     halted, bus_err     sticky status flags, cleared only by reset
//     state               current state encoding (debug)
//     retired_cnt,
//     stall_cnt           performance counters, present only when the macro
//                         MC_SEQ_PERF_CNT_EN is defined
// ---------------------------------------------------------------------------
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 15
`ifdef MC_SEQ_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opCode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic             halted,
    output logic             bus_err,
    output logic [2:0]       state
`ifdef MC_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state_q;
    state_t            state_d;
    op_class_t         dec_cls;
    op_class_t         cls_q;
    op_class_t         cur_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic              halted_q;
    logic              bus_err_q;
    logic              in_access;
    logic              stall;
    logic              timeout;
    logic              retire;
    ctrl_t             ctrl;

    mc_opclass_dec u_opclass_dec (
        .op_code  (opCode),
        .op_class (dec_cls)
    );

    // In DECODE the class is not latched yet, so that cycle uses the live
    // decode; every later state uses the latched copy.
    assign cur_cls = (state_q == ST_DECODE) ? dec_cls : cls_q;

    assign in_access = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign stall     = in_access && !mem_ack;
    assign timeout   = stall && (wait_cnt == WAIT_LIMIT);

    // -----------------------------------------------------------------------
    // Next state and control decode. Everything is a function of the
    // registered state and class, except the ack-qualified enables, BEQ's
    // pc_we (zero) and the SW retire pulse in MEM.
    // -----------------------------------------------------------------------
    always_comb begin
        ctrl    = '0;
        state_d = state_q;
        retire  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.pc_src    = PC_SRC_SEQ;
                ctrl.alu_src_b = ALU_B_FOUR;
                if (mem_ack) begin
                    ctrl.ir_we = 1'b1;
                    ctrl.pc_we = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end

            ST_DECODE: begin
                case (cur_cls)
                    CLS_J: begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_src = PC_SRC_JUMP;
                        retire      = 1'b1;
                    end
                    CLS_ILLEGAL: state_d = ST_HALT;
                    default:     state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                case (cur_cls)
                    CLS_RTYPE: begin
                        ctrl.alu_op = ALU_OP_FUNCT;
                        state_d     = ST_WB;
                    end
                    CLS_ADDI, CLS_LW, CLS_SW: begin
                        ctrl.alu_src_b = ALU_B_IMM;
                        ctrl.alu_op    = ALU_OP_ADD;
                        state_d        = is_mem_class(cur_cls) ? ST_MEM : ST_WB;
                    end
                    CLS_BEQ: begin
                        ctrl.alu_op = ALU_OP_SUB;
                        ctrl.pc_src = PC_SRC_BRANCH;
                        ctrl.pc_we  = zero;
                        retire      = 1'b1;
                    end
                    // J and ILLEGAL never reach EXEC; treat as a fault.
                    default: state_d = ST_HALT;
                endcase
            end

            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.mem_we  = (cur_cls == CLS_SW);
                if (mem_ack) begin
                    if (cur_cls == CLS_LW) begin
                        ctrl.mdr_we = 1'b1;
                        state_d     = ST_WB;
                    end else begin
                        retire = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = ST_HALT;
                end
            end

            ST_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = (cur_cls == CLS_RTYPE);
                ctrl.mem_to_reg = (cur_cls == CLS_LW);
                retire          = 1'b1;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_HALT;
            end
        endcase

        // Retire overrides the per-state next state: the next instruction
        // starts straight away only while run is held.
        if (retire) begin
            ctrl.instr_done = 1'b1;
            state_d         = run ? ST_FETCH : ST_IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // State, latched class, wait counter and sticky flags.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cls_q     <= CLS_RTYPE;
            wait_cnt  <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == ST_DECODE) cls_q <= dec_cls;

            // Any cycle without an outstanding stall (ack, or not in an
            // access state) clears the count, which also covers entry into
            // FETCH and MEM.
            if (stall && !timeout) wait_cnt <= wait_cnt + 1'b1;
            else                   wait_cnt <= '0;

            if (state_d == ST_HALT) halted_q  <= 1'b1;
            if (timeout)            bus_err_q <= 1'b1;
        end
    end

`ifdef MC_SEQ_PERF_CNT_EN
    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (ctrl.instr_done) retired_cnt <= retired_cnt + 1'b1;
            if (stall)           stall_cnt   <= stall_cnt + 1'b1;
        end
    end
`endif

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign iord       = ctrl.iord;
    assign ir_we      = ctrl.ir_we;
    assign mdr_we     = ctrl.mdr_we;
    assign pc_we      = ctrl.pc_we;
    assign reg_we     = ctrl.reg_we;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign instr_done = ctrl.instr_done;
    assign halted     = halted_q;
    assign bus_err    = bus_err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mc_sequencer
//   Directed test of mc_sequencer. Inputs change 1 time unit after the
//   rising edge and outputs are checked 2 units after it, well away from the
//   next edge. Performance counter checks are built only when
//   MC_SEQ_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mc_sequencer;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    logic       run;
    logic [5:0] opCode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, ir_we, mdr_we, pc_we, reg_we;
    logic [1:0] pc_src, alu_src_b, alu_op;
    logic       reg_dst, mem_to_reg, instr_done, halted, bus_err;
    logic [2:0] state;
`ifdef MC_SEQ_PERF_CNT_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    mc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opCode     (opCode),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_we      (ir_we),
        .mdr_we     (mdr_we),
        .pc_we      (pc_we),
        .reg_we     (reg_we),
        .pc_src     (pc_src),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .instr_done (instr_done),
        .halted     (halted),
        .bus_err    (bus_err),
        .state      (state)
`ifdef MC_SEQ_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         n_retired = 0;
    int         hold_cnt;
    logic [2:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All datapath control outputs packed together, for "everything is 0" checks.
    function automatic logic [15:0] all_ctl();
        return {mem_req, mem_we, iord, ir_we, mdr_we, pc_we, reg_we, reg_dst,
                mem_to_reg, instr_done, pc_src, alu_src_b, alu_op};
    endfunction

    // ---------------- driver tasks ----------------
    // Advance one clock, apply mem_ack for the new cycle and let it settle.
    task automatic step(input logic ack);
        @(posedge clk);
        #1;
        mem_ack = ack;
        #1;
        if (instr_done === 1'b1) n_retired++;
    endtask

    // Step with ack=1 through the states queued in exp_q, checking each.
    task automatic run_expected(input string tag);
        logic [2:0] exp_state;
        while (exp_q.size() > 0) begin
            exp_state = exp_q.pop_front();
            step(1'b1);
            check(tag, {29'd0, state}, {29'd0, exp_state});
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b0;
        #1;
        check({tag, "_state"}, {29'd0, state}, 32'd0);
        check({tag, "_ctl"}, {16'd0, all_ctl()}, 32'd0);
        check({tag, "_flags"}, {30'd0, halted, bus_err}, 32'd0);
`ifdef MC_SEQ_PERF_CNT_EN
        check({tag, "_retired_cnt"}, retired_cnt, 32'd0);
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
        n_retired = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b0;
        run     = 1'b0;
        opCode  = OP_RTYPE;
        zero    = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_state", {29'd0, state}, 32'd0);
        check("reset_ctl", {16'd0, all_ctl()}, 32'd0);
        check("reset_flags", {30'd0, halted, bus_err}, 32'd0);

        // Release reset with run=1 and ack tied high.
        @(posedge clk);
        #1;
        rst     = 1'b1;
        run     = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("idle_state", {29'd0, state}, 32'd0);

        // ---- RTYPE: 001,010,011,101 then FETCH again ----
        step(1'b1);
        check("rt_fetch_state", {29'd0, state}, 32'd1);
        // {mem_req, iord, ir_we, pc_we, pc_src, alu_src_b}
        check("rt_fetch_ctl", {24'd0, mem_req, iord, ir_we, pc_we, pc_src, alu_src_b}, 32'b1011_0001);
        step(1'b1);
        check("rt_decode_state", {29'd0, state}, 32'd2);
        step(1'b1);
        check("rt_exec_state", {29'd0, state}, 32'd3);
        check("rt_exec_alu_op", {30'd0, alu_op}, 32'd2);
        step(1'b1);
        check("rt_wb_state", {29'd0, state}, 32'd5);
        // {reg_we, reg_dst, mem_to_reg, instr_done}
        check("rt_wb_ctl", {28'd0, reg_we, reg_dst, mem_to_reg, instr_done}, 32'b1101);
        opCode = OP_LW;
        step(1'b1);
        check("rt_next_fetch", {29'd0, state}, 32'd1);

        // ---- LW with ack 3 cycles late in MEM: 8 cycles total ----
        step(1'b1);
        check("lw_decode_state", {29'd0, state}, 32'd2);
        step(1'b1);
        check("lw_exec_state", {29'd0, state}, 32'd3);
        check("lw_exec_sel", {28'd0, alu_src_b, alu_op}, 32'b1000);
        hold_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(i == 3);
            check("lw_mem_state", {29'd0, state}, 32'd4);
            check("lw_mem_we", {31'd0, mem_we}, 32'd0);
            check("lw_mdr_we", {31'd0, mdr_we}, (i == 3) ? 32'd1 : 32'd0);
            if (mem_req === 1'b1 && iord === 1'b1) hold_cnt++;
        end
        check("lw_req_hold", hold_cnt, 32'd4);
        step(1'b1);
        check("lw_wb_state", {29'd0, state}, 32'd5);
        check("lw_wb_ctl", {28'd0, reg_we, reg_dst, mem_to_reg, instr_done}, 32'b1011);

        // ---- BEQ taken then not taken: 3 cycles each ----
        opCode = OP_BEQ;
        zero   = 1'b1;
        exp_q  = '{3'd1, 3'd2, 3'd3};
        run_expected("beq1_state");
        // {pc_we, pc_src, alu_op, instr_done}
        check("beq_taken_ctl", {26'd0, pc_we, pc_src, alu_op, instr_done}, 32'b1_01_01_1);
        zero  = 1'b0;
        exp_q = '{3'd1, 3'd2, 3'd3};
        run_expected("beq0_state");
        check("beq_not_taken_ctl", {26'd0, pc_we, pc_src, alu_op, instr_done}, 32'b0_01_01_1);

        // ---- J: retires in DECODE; run dropped so it goes to IDLE ----
        opCode = OP_J;
        exp_q  = '{3'd1, 3'd2};
        run_expected("j_state");
        check("j_decode_ctl", {28'd0, pc_we, pc_src, instr_done}, 32'b1101);
        run = 1'b0;
        step(1'b0);
        check("j_to_idle", {29'd0, state}, 32'd0);
        check("idle_ctl", {16'd0, all_ctl()}, 32'd0);
        step(1'b1);
        check("idle_ack_ignored", {29'd0, state}, 32'd0);

        // ---- SW with same-cycle ack: 4 cycles ----
        run    = 1'b1;
        opCode = OP_SW;
        exp_q  = '{3'd1, 3'd2, 3'd3, 3'd4};
        run_expected("sw_state");
        // {mem_req, iord, mem_we, instr_done, mdr_we}
        check("sw_mem_ctl", {27'd0, mem_req, iord, mem_we, instr_done, mdr_we}, 32'b11110);
        run = 1'b0;
        step(1'b1);
        check("sw_to_idle", {29'd0, state}, 32'd0);

        // ---- ADDI; run dropped mid-instruction does not abort ----
        run    = 1'b1;
        opCode = OP_ADDI;
        exp_q  = '{3'd1, 3'd2, 3'd3};
        run_expected("addi_state");
        check("addi_exec_sel", {28'd0, alu_src_b, alu_op}, 32'b1000);
        run = 1'b0;
        step(1'b1);
        check("addi_wb_state", {29'd0, state}, 32'd5);
        check("addi_wb_ctl", {28'd0, reg_we, reg_dst, mem_to_reg, instr_done}, 32'b1001);
        step(1'b1);
        check("addi_to_idle", {29'd0, state}, 32'd0);

        // ---- FETCH ack arriving exactly when the wait count hits 15 ----
        run    = 1'b1;
        opCode = OP_RTYPE;
        for (int i = 0; i < 15; i++) begin
            step(1'b0);
            check("late_ack_wait", {29'd0, state}, 32'd1);
        end
        step(1'b1);
        check("late_ack_fetch", {29'd0, state}, 32'd1);
        check("late_ack_ir_we", {31'd0, ir_we}, 32'd1);
        run = 1'b0;
        step(1'b1);
        check("late_ack_decode", {29'd0, state}, 32'd2);
        check("late_ack_no_err", {31'd0, bus_err}, 32'd0);
        exp_q = '{3'd3, 3'd5, 3'd0};
        run_expected("late_ack_rest");

        // ---- FETCH timeout: 15 wait cycles counted, next unacked -> HALT ----
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b0);
            check("timeout_wait", {29'd0, state}, 32'd1);
        end
        step(1'b0);
        check("timeout_state", {29'd0, state}, 32'd6);
        check("timeout_flags", {30'd0, halted, bus_err}, 32'b11);
        check("timeout_mem_req", {31'd0, mem_req}, 32'd0);
        step(1'b1);
        check("timeout_stays_halt", {29'd0, state}, 32'd6);
`ifdef MC_SEQ_PERF_CNT_EN
        check("perf_retired", retired_cnt, n_retired);
        // Stalls: LW 3 + late ack 15 + timeout 16.
        check("perf_stall", stall_cnt, 32'd34);
`endif
        reset_pulse("rst_after_timeout");

        // ---- Illegal opcode: DECODE -> HALT, run has no effect ----
        run    = 1'b1;
        opCode = OP_BAD;
        exp_q  = '{3'd1, 3'd2, 3'd6};
        run_expected("illegal_state");
        check("illegal_flags", {30'd0, halted, bus_err}, 32'b10);
        check("illegal_ctl", {16'd0, all_ctl()}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1'b1);
            check("illegal_held", {29'd0, state, halted}, 32'b1101);
        end
        reset_pulse("rst_after_illegal");

        // ---- Reset asserted mid-MEM on a SW ----
        run    = 1'b1;
        opCode = OP_SW;
        exp_q  = '{3'd1, 3'd2, 3'd3};
        run_expected("sw_rst_state");
        step(1'b0);
        check("sw_rst_mem_ctl", {29'd0, state == 3'd4, mem_req, mem_we}, 32'b111);
        reset_pulse("rst_mid_mem");
        check("after_rst_idle", {29'd0, state}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
